// File: rtl/rect_plotter_if.sv
// Command/pixel bundle between a renderer and rect_plotter.
// The master drives the rectangle request; the slave returns status and the VGA write port.
interface rect_plotter_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SIZE_W   = 5
);
  logic                go;
  logic [X_W-1:0]      x_in;
  logic [Y_W-1:0]      y_in;
  logic [SIZE_W-1:0]   w_in;
  logic [SIZE_W-1:0]   h_in;
  logic [COLOUR_W-1:0] colour_in;
  logic                erase;
  logic                busy;
  logic                done;
  logic                plot;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;

  modport master (
    output go, x_in, y_in, w_in, h_in, colour_in, erase,
    input  busy, done, plot, x_out, y_out, colour_out
  );

  modport slave (
    input  go, x_in, y_in, w_in, h_in, colour_in, erase,
    output busy, done, plot, x_out, y_out, colour_out
  );
endinterface

// File: rtl/rect_plotter.sv
// Rectangle rasteriser: one registered pixel per clock, row-major, into the VGA write port.
// Define RECT_PLOTTER_CLIP_EN to suppress plot for pixels beyond X_MAX/Y_MAX.
module rect_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SIZE_W   = 5,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119
) (
  input  logic           clk,
  input  logic           resetn,
  rect_plotter_if.slave  rect_io
);
  // state | meaning
  // IDLE  | waiting for go
  // DRAW  | emitting one pixel per cycle (busy=1)
  // FIN   | single done cycle; go is accepted here too
  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

`ifdef RECT_PLOTTER_CLIP_EN
  localparam int XS_W = X_W + 1;
  localparam int YS_W = Y_W + 1;
`else
  localparam int XS_W = X_W;
  localparam int YS_W = Y_W;
`endif

  state_t              state_q, state_d;
  logic [X_W-1:0]      x0_q, x0_d;
  logic [Y_W-1:0]      y0_q, y0_d;
  logic [SIZE_W-1:0]   w_q, w_d, h_q, h_d;
  logic [SIZE_W-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [COLOUR_W-1:0] col_q, col_d;
  logic                plot_q, plot_d;
  logic [X_W-1:0]      x_out_q, x_out_d;
  logic [Y_W-1:0]      y_out_q, y_out_d;
  logic [COLOUR_W-1:0] colour_out_q, colour_out_d;
  logic [XS_W-1:0]     x_sum;
  logic [YS_W-1:0]     y_sum;
  logic                on_screen;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      col_q        <= '0;
      plot_q       <= 1'b0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      w_q          <= w_d;
      h_q          <= h_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      col_q        <= col_d;
      plot_q       <= plot_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      colour_out_q <= colour_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    w_d          = w_q;
    h_d          = h_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    col_d        = col_q;
    plot_d       = 1'b0;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    colour_out_d = colour_out_q;
    x_sum        = '0;
    y_sum        = '0;
    on_screen    = 1'b1;

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (rect_io.go) begin
          x0_d  = rect_io.x_in;
          y0_d  = rect_io.y_in;
          w_d   = rect_io.w_in;
          h_d   = rect_io.h_in;
          col_d = rect_io.erase ? '0 : rect_io.colour_in;
          cx_d  = '0;
          cy_d  = '0;
          state_d = (rect_io.w_in == '0 || rect_io.h_in == '0) ? FIN : DRAW;
        end
      end
      DRAW: begin
        if (cx_q == w_q - SIZE_W'(1)) begin
          cx_d = '0;
          if (cy_q == h_q - SIZE_W'(1)) state_d = FIN;
          else                          cy_d    = cy_q + SIZE_W'(1);
        end else begin
          cx_d = cx_q + SIZE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The pixel registered this edge is the one addressed by the next counter values.
    x_sum = XS_W'(x0_d) + XS_W'(cx_d);
    y_sum = YS_W'(y0_d) + YS_W'(cy_d);
`ifdef RECT_PLOTTER_CLIP_EN
    on_screen = (x_sum <= XS_W'(X_MAX)) && (y_sum <= YS_W'(Y_MAX));
`endif
    if (state_d == DRAW) begin
      plot_d       = on_screen;
      x_out_d      = x_sum[X_W-1:0];
      y_out_d      = y_sum[Y_W-1:0];
      colour_out_d = col_d;
    end
  end

  assign rect_io.busy       = (state_q == DRAW);
  assign rect_io.done       = (state_q == FIN);
  assign rect_io.plot       = plot_q;
  assign rect_io.x_out      = x_out_q;
  assign rect_io.y_out      = y_out_q;
  assign rect_io.colour_out = colour_out_q;
endmodule

// File: tb/tb_rect_plotter.sv
// Self-checking bench for rect_plotter: vector table plus pixel scoreboard.
module tb_rect_plotter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rect_plotter_if #(.X_W(8), .Y_W(7), .COLOUR_W(3), .SIZE_W(5)) rif ();

  rect_plotter #(
    .X_W(8), .Y_W(7), .COLOUR_W(3), .SIZE_W(5), .X_MAX(159), .Y_MAX(119)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .rect_io(rif.slave)
  );

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [4:0] w;
    logic [4:0] h;
    logic [2:0] col;
    logic       erase;
    int         exp_cycles;
  } vec_t;

  typedef struct {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } pix_t;

  pix_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: expected pixel stream for one rectangle, at most n_max slots.
  task automatic push_rect(input vec_t v, input int n_max);
    int   n;
    pix_t p;
    n = 0;
    for (int cy = 0; cy < int'(v.h); cy++) begin
      for (int cx = 0; cx < int'(v.w); cx++) begin
        if (n < n_max) begin
`ifdef RECT_PLOTTER_CLIP_EN
          p.plot = ((int'(v.x) + cx) <= 159) && ((int'(v.y) + cy) <= 119);
`else
          p.plot = 1'b1;
`endif
          p.x   = 8'(int'(v.x) + cx);
          p.y   = 7'(int'(v.y) + cy);
          p.col = v.erase ? 3'd0 : v.col;
          sb.push_back(p);
        end
        n++;
      end
    end
  endtask

  always @(negedge clk) begin
    pix_t e;
    if (rif.busy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got pixel x=%0d y=%0d required none", rif.x_out, rif.y_out);
      end else begin
        e = sb.pop_front();
        check("pix_plot", {63'd0, rif.plot}, {63'd0, e.plot});
        if (e.plot)
          check("pix_xyc", {rif.x_out, rif.y_out, rif.colour_out}, {e.x, e.y, e.col});
      end
    end else if (rif.plot) begin
      n_cmp++;
      n_err++;
      $display("FAIL plot_outside_draw: got plot=1 required 0");
    end
  end

  task automatic drive(input vec_t v, input logic go_v);
    rif.go        = go_v;
    rif.x_in      = v.x;
    rif.y_in      = v.y;
    rif.w_in      = v.w;
    rif.h_in      = v.h;
    rif.colour_in = v.col;
    rif.erase     = v.erase;
  endtask

  task automatic wait_busy(output int cyc);
    cyc = 0;
    while (rif.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    drive(v, 1'b1);
    push_rect(v, 1 << 12);
    @(negedge clk);
    rif.go = 1'b0;
    wait_busy(cyc);
    check({name, "_cycles"}, cyc, v.exp_cycles);
    check({name, "_done"}, {63'd0, rif.done}, 64'd1);
    check({name, "_sb_empty"}, sb.size(), 64'd0);
    @(negedge clk);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t a, b, c, r, z;
    int   cyc;
    logic seen_done;

    tbl[0] = '{8'd10,  7'd20,  5'd4,  5'd4, 3'd5, 1'b0, 16};
    tbl[1] = '{8'd0,   7'd0,   5'd2,  5'd3, 3'd7, 1'b1, 6};
    tbl[2] = '{8'd0,   7'd0,   5'd0,  5'd5, 3'd3, 1'b0, 0};
    tbl[3] = '{8'd12,  7'd12,  5'd3,  5'd0, 3'd1, 1'b0, 0};
    tbl[4] = '{8'd158, 7'd118, 5'd4,  5'd3, 3'd2, 1'b0, 12};
    tbl[5] = '{8'd254, 7'd126, 5'd3,  5'd3, 3'd6, 1'b0, 9};
    tbl[6] = '{8'd5,   7'd5,   5'd31, 5'd2, 3'd1, 1'b0, 62};
    tbl[7] = '{8'd159, 7'd119, 5'd1,  5'd1, 3'd7, 1'b0, 1};

    z = '{8'd0, 7'd0, 5'd0, 5'd0, 3'd0, 1'b0, 0};
    drive(z, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_outs",
          {rif.busy, rif.done, rif.plot, rif.x_out, rif.y_out, rif.colour_out}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back: second go presented during the FIN cycle of a 1x1.
    a = '{8'd50, 7'd60, 5'd1, 5'd1, 3'd2, 1'b0, 1};
    b = '{8'd70, 7'd80, 5'd2, 5'd1, 3'd4, 1'b0, 2};
    drive(a, 1'b1);
    push_rect(a, 1 << 12);
    @(negedge clk);
    check("b2b_a_busy", {63'd0, rif.busy}, 64'd1);
    drive(b, 1'b1);
    push_rect(b, 1 << 12);
    @(negedge clk);
    check("b2b_fin", {62'd0, rif.done, rif.busy}, 64'd2);
    @(negedge clk);
    check("b2b_restart_busy", {63'd0, rif.busy}, 64'd1);
    rif.go = 1'b0;
    wait_busy(cyc);
    check("b2b_b_cycles", cyc, 64'd2);
    check("b2b_b_done", {63'd0, rif.done}, 64'd1);
    @(negedge clk);

    // go held through DRAW of a 3x1: ignored until FIN, then restarts once.
    c = '{8'd100, 7'd10, 5'd3, 5'd1, 3'd1, 1'b0, 3};
    drive(c, 1'b1);
    push_rect(c, 1 << 12);
    push_rect(c, 1 << 12);
    @(negedge clk);
    wait_busy(cyc);
    check("held_first_cycles", cyc, 64'd3);
    check("held_first_done", {63'd0, rif.done}, 64'd1);
    @(negedge clk);
    rif.go = 1'b0;
    wait_busy(cyc);
    check("held_second_cycles", cyc, 64'd3);
    check("held_second_done", {63'd0, rif.done}, 64'd1);
    check("held_sb_empty", sb.size(), 64'd0);
    @(negedge clk);

    // Reset during pixel 5 of a 4x4.
    r = '{8'd30, 7'd40, 5'd4, 5'd4, 3'd6, 1'b0, 16};
    drive(r, 1'b1);
    push_rect(r, 5);
    @(negedge clk);
    rif.go = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midreset_outs", {rif.plot, rif.busy, rif.done, rif.x_out, rif.y_out}, 64'd0);
    check("midreset_sb_empty", sb.size(), 64'd0);
    resetn = 1'b1;
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_done = seen_done | rif.done | rif.busy;
    end
    check("midreset_no_done", {63'd0, seen_done}, 64'd0);
    r = '{8'd1, 7'd2, 5'd2, 5'd2, 3'd3, 1'b0, 4};
    run_vec(r, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
